bcd_timer_counter: RTL and testbench

//  Parametrised multi-digit BCD up/down counter for the timer datapath (e.g. MM:SS display).

---
 rtl/bcd_timer_counter_if.sv | 37 +++
 rtl/bcd_timer_counter.sv | 119 +++++++++++
 tb/tb_bcd_timer_counter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/bcd_timer_counter_if.sv
// Bus bundle for the multi-digit BCD timer counter.
//
// Groups the control inputs and the status/value outputs of the counter so the
// counter and its driver share one connection. Clock and reset stay outside.
//   loadn  : synchronous load strobe, active low
//   data   : load value, digit i at data[4i+3:4i]
//   en     : count enable, active high
//   up     : count direction, 1 = up, 0 = down
//   digits : current counter value, digit i at digits[4i+3:4i]
//   tc     : terminal count (combinational, qualified by en)
//   zero   : all digits are 0 (combinational)
//   done   : registered one-cycle pulse when a down count reaches 0
//
// master : the side that drives loadn/data/en/up (controller or bench)
// slave  : the counter itself
interface bcd_timer_counter_if #(
  parameter int NDIGITS = 4
);
  logic                   loadn;
  logic [4*NDIGITS-1:0]   data;
  logic                   en;
  logic                   up;
  logic [4*NDIGITS-1:0]   digits;
  logic                   tc;
  logic                   zero;
  logic                   done;

  modport master (
    output loadn, data, en, up,
    input  digits, tc, zero, done
  );

  modport slave (
    input  loadn, data, en, up,
    output digits, tc, zero, done
  );
endinterface

// File: rtl/bcd_timer_counter.sv
// Parametrised multi-digit BCD up/down counter for the timer datapath.
//
// Each digit has its own modulus (MODS nibble i), so the digit chain counts in
// mixed radix, e.g. MODS=16'hAA6A gives a MM:SS display (seconds-tens mod 6).
//   clock  : rising-edge clock
//   clearn : asynchronous reset, active low; clears digits and done
//   bus    : slave side of bcd_timer_counter_if (loadn, data, en, up in;
//            digits, tc, zero, done out)
//
// Edge priority is clearn > loadn > en. Loaded digits are clamped to MOD-1, so
// the register never holds an out-of-range digit. With STOP_AT_END=1 the
// counter sticks at the terminal value (all-zero down, all-max up); with
// STOP_AT_END=0 it wraps through the natural carry/borrow chain.
module bcd_timer_counter #(
  parameter int                 NDIGITS     = 4,
  parameter logic [4*NDIGITS-1:0] MODS      = 16'hAA6A,
  parameter int                 STOP_AT_END = 1
) (
  input  logic               clock,
  input  logic               clearn,
  bcd_timer_counter_if.slave bus
);

  localparam int DW = 4 * NDIGITS;

  // Elaboration-time guard on the per-digit moduli.
  for (genvar g = 0; g < NDIGITS; g++) begin : g_mod_chk
    localparam int MOD_G = int'(MODS[4*g +: 4]);
    if (MOD_G < 2 || MOD_G > 10) begin : g_bad_mod
      $error("bcd_timer_counter: digit %0d modulus %0d outside 2..10", g, MOD_G);
    end
  end

  // Largest legal value of digit i.
  function automatic logic [3:0] mod_max(input int i);
    logic [3:0] m;
    m = MODS[4*i +: 4];
    return m - 4'd1;
  endfunction

  // Saturate a loaded digit into the legal range of its position.
  function automatic logic [3:0] clamp_digit(input logic [3:0] v, input logic [3:0] mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [3:0] inc_digit(input logic [3:0] v, input logic [3:0] mx);
    return (v == mx) ? 4'd0 : v + 4'd1;
  endfunction

  function automatic logic [3:0] dec_digit(input logic [3:0] v, input logic [3:0] mx);
    return (v == 4'd0) ? mx : v - 4'd1;
  endfunction

  logic [DW-1:0] digits_q, digits_d;
  logic          done_q, done_d;

  logic          all_zero;
  logic          all_max;
  logic          hold_at_end;
  logic          chain;
  logic [3:0]    cur;

  // Terminal-value detection on the current register contents.
  always_comb begin
    all_zero = 1'b1;
    all_max  = 1'b1;
    for (int i = 0; i < NDIGITS; i++) begin
      if (digits_q[4*i +: 4] != 4'd0)       all_zero = 1'b0;
      if (digits_q[4*i +: 4] != mod_max(i)) all_max  = 1'b0;
    end
  end

  // At the terminal value a stopping counter ignores the enable entirely;
  // a wrapping counter needs nothing special because the carry/borrow chain
  // already takes all-zero to all-max and back.
  assign hold_at_end = (STOP_AT_END != 0) && (bus.up ? all_max : all_zero);

  // Next-value logic. chain carries the "all lower digits at their rollover
  // point" condition from digit 0 upwards; digit 0 always sees chain=1.
  always_comb begin
    digits_d = digits_q;
    done_d   = 1'b0;
    chain    = 1'b1;
    cur      = 4'd0;
    if (!bus.loadn) begin
      for (int i = 0; i < NDIGITS; i++) begin
        digits_d[4*i +: 4] = clamp_digit(bus.data[4*i +: 4], mod_max(i));
      end
    end else if (bus.en && !hold_at_end) begin
      for (int i = 0; i < NDIGITS; i++) begin
        cur = digits_q[4*i +: 4];
        if (chain) begin
          digits_d[4*i +: 4] = bus.up ? inc_digit(cur, mod_max(i))
                                      : dec_digit(cur, mod_max(i));
        end
        chain = chain & (bus.up ? (cur == mod_max(i)) : (cur == 4'd0));
      end
      // Only a down step from a non-zero value into zero fires done; the
      // wrap from zero and every up step leave it low.
      done_d = !bus.up && !all_zero && (digits_d == '0);
    end
  end

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      digits_q <= '0;
      done_q   <= 1'b0;
    end else begin
      digits_q <= digits_d;
      done_q   <= done_d;
    end
  end

  assign bus.digits = digits_q;
  assign bus.done   = done_q;
  assign bus.zero   = all_zero;
  assign bus.tc     = bus.en & (bus.up ? all_max : all_zero);

endmodule

// File: tb/tb_bcd_timer_counter.sv
// Bench for bcd_timer_counter: a stopping instance driven from a vector table
// plus hand-written sequences, and a wrapping instance for the wrap corners.
module tb_bcd_timer_counter;

  logic clock;
  logic clearn;

  bcd_timer_counter_if #(.NDIGITS(4)) bus_a ();
  bcd_timer_counter_if #(.NDIGITS(4)) bus_b ();

  bcd_timer_counter #(.NDIGITS(4), .MODS(16'hAA6A), .STOP_AT_END(1)) dut_a (
    .clock  (clock),
    .clearn (clearn),
    .bus    (bus_a)
  );

  bcd_timer_counter #(.NDIGITS(4), .MODS(16'hAA6A), .STOP_AT_END(0)) dut_b (
    .clock  (clock),
    .clearn (clearn),
    .bus    (bus_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        loadn;
    logic [15:0] data;
    logic        en;
    logic        up;
    logic [15:0] exp_dig;
    logic        exp_tc;
    logic        exp_zero;
    logic        exp_done;
  } vec_t;

  vec_t vecs [24];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_a(input logic loadn, input logic [15:0] data, input logic en, input logic up);
    bus_a.loadn = loadn;
    bus_a.data  = data;
    bus_a.en    = en;
    bus_a.up    = up;
  endtask

  task automatic drive_b(input logic loadn, input logic [15:0] data, input logic en, input logic up);
    bus_b.loadn = loadn;
    bus_b.data  = data;
    bus_b.en    = en;
    bus_b.up    = up;
  endtask

  initial begin
    //              loadn data     en up  digits   tc zero done
    vecs[0]  = '{1'b0, 16'h0130, 1'b0, 1'b0, 16'h0130, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 16'h0129, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 16'h0128, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 16'h0100, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 16'h0059, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 16'h0002, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 16'h0070, 1'b0, 1'b0, 16'h0050, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 16'h0500, 1'b1, 1'b0, 16'h0500, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 16'h0000, 1'b1, 1'b0, 16'h0459, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 16'h0000, 1'b1, 1'b1, 16'h0500, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 16'h9958, 1'b1, 1'b1, 16'h9958, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 16'h0000, 1'b1, 1'b1, 16'h9959, 1'b1, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 16'h0000, 1'b1, 1'b1, 16'h9959, 1'b1, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 16'h0000, 1'b1, 1'b0, 16'h9958, 1'b0, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 16'h0FFF, 1'b0, 1'b1, 16'h0959, 1'b0, 1'b0, 1'b0};
    vecs[21] = '{1'b1, 16'h0000, 1'b1, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0};
    vecs[22] = '{1'b1, 16'h0000, 1'b1, 1'b0, 16'h0959, 1'b0, 1'b0, 1'b0};
    vecs[23] = '{1'b1, 16'h0000, 1'b0, 1'b0, 16'h0959, 1'b0, 1'b0, 1'b0};

    // Reset state
    clearn = 1'b0;
    drive_a(1'b1, 16'h0000, 1'b0, 1'b0);
    drive_b(1'b1, 16'h0000, 1'b0, 1'b0);
    #2;
    chk("reset digits", bus_a.digits, 16'h0000);
    chk("reset done",   {15'd0, bus_a.done}, 16'd0);
    chk("reset zero",   {15'd0, bus_a.zero}, 16'd1);
    @(negedge clock);
    clearn = 1'b1;
    tick();

    // Table-driven vectors on the stopping counter
    for (int i = 0; i < 24; i++) begin
      drive_a(vecs[i].loadn, vecs[i].data, vecs[i].en, vecs[i].up);
      tick();
      chk($sformatf("v%0d digits", i), bus_a.digits, vecs[i].exp_dig);
      chk($sformatf("v%0d tc", i),     {15'd0, bus_a.tc},   {15'd0, vecs[i].exp_tc});
      chk($sformatf("v%0d zero", i),   {15'd0, bus_a.zero}, {15'd0, vecs[i].exp_zero});
      chk($sformatf("v%0d done", i),   {15'd0, bus_a.done}, {15'd0, vecs[i].exp_done});
    end

    // Long down count 01:30 -> 01:00 -> 00:59
    drive_a(1'b0, 16'h0130, 1'b0, 1'b0);
    tick();
    drive_a(1'b1, 16'h0000, 1'b1, 1'b0);
    for (int k = 0; k < 30; k++) tick();
    chk("seq1 0100", bus_a.digits, 16'h0100);
    tick();
    chk("seq1 0059", bus_a.digits, 16'h0059);
    drive_a(1'b1, 16'h0000, 1'b0, 1'b0);

    // Wrapping counter: up through max to zero, down through zero to max
    drive_b(1'b0, 16'h9958, 1'b0, 1'b1);
    tick();
    chk("wrap load", bus_b.digits, 16'h9958);
    drive_b(1'b1, 16'h0000, 1'b1, 1'b1);
    tick();
    chk("wrap 9959",    bus_b.digits, 16'h9959);
    chk("wrap tc max",  {15'd0, bus_b.tc}, 16'd1);
    tick();
    chk("wrap up 0000", bus_b.digits, 16'h0000);
    chk("wrap up zero", {15'd0, bus_b.zero}, 16'd1);
    chk("wrap up done", {15'd0, bus_b.done}, 16'd0);
    drive_b(1'b1, 16'h0000, 1'b1, 1'b0);
    tick();
    chk("wrap dn 9959", bus_b.digits, 16'h9959);
    chk("wrap dn done", {15'd0, bus_b.done}, 16'd0);
    drive_b(1'b0, 16'h0001, 1'b0, 1'b0);
    tick();
    drive_b(1'b1, 16'h0000, 1'b1, 1'b0);
    tick();
    chk("wrap 1to0 dig",  bus_b.digits, 16'h0000);
    chk("wrap 1to0 done", {15'd0, bus_b.done}, 16'd1);
    tick();
    chk("wrap after 0",   bus_b.digits, 16'h9959);
    chk("wrap done drop", {15'd0, bus_b.done}, 16'd0);
    drive_b(1'b1, 16'h0000, 1'b0, 1'b0);

    // Asynchronous clear in the middle of a count
    drive_a(1'b0, 16'h0043, 1'b0, 1'b0);
    tick();
    drive_a(1'b1, 16'h0000, 1'b1, 1'b0);
    tick();
    chk("clr pre 0042", bus_a.digits, 16'h0042);
    #2;
    clearn = 1'b0;
    #1;
    chk("clr digits", bus_a.digits, 16'h0000);
    chk("clr done",   {15'd0, bus_a.done}, 16'd0);
    #1;
    clearn = 1'b1;
    tick();
    chk("clr post hold", bus_a.digits, 16'h0000);
    chk("clr post done", {15'd0, bus_a.done}, 16'd0);
    chk("clr post tc",   {15'd0, bus_a.tc},   16'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
